calc_operand_sequencer: RTL
===========================

Name: calc_operand_sequencer

Overview:
- Upstream stage of the combinational 4-bit signed calculator on the DE2 board.
- Debounces the raw active-low KEY[2:0] pushbuttons and captures switch operands into registers.
- Drives stable A, B and OP into the calculator. Supports chaining, where the calculator result R is fed back as the next A.
- Tracks overflow as a sticky error, and counts chained operations for display.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronized key level must differ from the debounced level before the debounced level flips (10 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- KEY  in  3  raw pushbuttons, active-low, asynchronous. KEY[0]=load, KEY[1]=next op, KEY[2]=chain.
- SW  in  8  operand switches: SW[7:4] new A, SW[3:0] new B (two's complement).
- R  in  4  signed result returned from the calculator.
- ovf  in  1  overflow flag returned from the calculator.
- A  out  4  registered operand A to the calculator.
- B  out  4  registered operand B to the calculator.
- OP  out  3  registered operation code to the calculator.
- Error  out  1  sticky overflow error.
- Loaded  out  1  high once operands are valid (state != IDLE).
- ChainCount  out  4  number of chain operations since last load; saturates at 15.

Behaviour:
- Reset (sync, highest priority, any state):
  - A=0, B=0, OP=0, Error=0, Loaded=0, ChainCount=0, state=IDLE.
  - Synchronizer FFs and debounced levels = 1 (released); debounce counters = 0.
- Debounce, per key:
  - 2-FF synchronizer, then a counter.
  - Counter increments while synced != debounced and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - Press event = registered one-cycle pulse on a debounced 1->0 transition. Releases generate no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Latency: raw KEY first sampled low at edge 0 and held -> architectural registers update at edge DEBOUNCE_CYCLES+3.
- Event priority when pulses coincide: load > chain > next-op. Only the highest-priority event acts that cycle; the others are dropped.
- States: IDLE, LOADED, ERROR.
- IDLE:
  - load -> A=SW[7:4], B=SW[3:0], ChainCount=0, go to LOADED.
  - Chain and next-op are ignored.
- LOADED:
  - load -> recapture A and B as in IDLE, ChainCount=0.
  - next-op -> OP=OP+1, wrapping 7->0. A and B are unchanged.
  - chain with ovf=0 at the event cycle -> A=R, B=SW[3:0], ChainCount=min(ChainCount+1,15).
  - chain with ovf=1 at the event cycle -> A and B hold, Error=1, go to ERROR.
- ERROR:
  - load -> recapture A and B, ChainCount=0, Error=0, go to LOADED.
  - next-op -> OP=OP+1; the state stays ERROR.
  - Chain is ignored.
- R and ovf are sampled on the event cycle. They are combinational from the current A, B and OP, which are stable, so no settle cycle is needed.
- OP persists across load and error; only reset clears it.
- Loaded = (state != IDLE).
- Outputs are registered and change only on event cycles or reset.
- Reset mid-debounce discards the in-progress count; no event is produced.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then KEY[0] low for 20 cycles with SW=8'h3A:
  - Exactly one load event.
  - A=3, B=4'hA (-6), Loaded=1 at edge 7; ChainCount=0.
- Glitch: KEY[0] low for 3 cycles, then high -> no event; A=0, Loaded=0 throughout.
- Op wrap: from LOADED, press KEY[1] 9 times, each press held 10 cycles and released 10 cycles -> OP sequence 1..7,0,1; A and B unchanged.
- Chain: A=2, B=1, bench returns R=4'h3, ovf=0. Press KEY[2] with SW[3:0]=4'h2 -> A=3, B=2, ChainCount=1. Repeat 16 chains with ovf=0 -> ChainCount saturates at 15.
- Overflow:
  - Bench drives ovf=1 during a KEY[2] press -> Error=1, A/B hold, state ERROR.
  - Further KEY[2] presses ignored.
  - KEY[0] press with SW=8'hF1 -> Error=0, A=-1, B=1, ChainCount=0.
- Simultaneous KEY[0] and KEY[2] pressed on the same cycle in LOADED -> load wins (A=SW[7:4]); ChainCount=0. Assert Reset mid-debounce of KEY[1] -> no OP change after release.

Source files
------------

// File: rtl/calc_operand_sequencer.sv
// Operand sequencer in front of the 4-bit signed calculator: debounces the
// pushbuttons, captures switch operands, chains results and tracks overflow.
module calc_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [2:0] KEY,
  input  logic [7:0] SW,
  input  logic [3:0] R,
  input  logic       ovf,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] OP,
  output logic       Error,
  output logic       Loaded,
  output logic [3:0] ChainCount
);

  localparam int unsigned NKEYS = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] CC_MAX = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_LOADED, S_ERROR} state_t;

  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;
  logic [NKEYS-1:0] r_deb;
  logic [NKEYS-1:0] r_deb_q;
  logic [NKEYS-1:0] r_press;
  logic [CNT_W-1:0] r_cnt [NKEYS];

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_op;
  logic       r_error;
  logic       r_loaded;
  logic [3:0] r_cc;

  logic w_load;
  logic w_chain;
  logic w_next;

  // Synchronize, debounce and turn each debounced falling edge into a pulse.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_deb   <= '1;
      r_deb_q <= '1;
      r_press <= '0;
      for (int k = 0; k < NKEYS; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_press <= r_deb_q & ~r_deb;
      for (int k = 0; k < NKEYS; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_deb[k] <= r_sync2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Coincident pulses resolve as load > chain > next-op.
  assign w_load  = r_press[0];
  assign w_chain = r_press[2] & ~r_press[0];
  assign w_next  = r_press[1] & ~r_press[0] & ~r_press[2];

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_error  <= 1'b0;
      r_loaded <= 1'b0;
      r_cc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_a      <= SW[7:4];
            r_b      <= SW[3:0];
            r_cc     <= '0;
            r_loaded <= 1'b1;
            r_state  <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (w_load) begin
            r_a  <= SW[7:4];
            r_b  <= SW[3:0];
            r_cc <= '0;
          end else if (w_chain) begin
            // R/ovf are already settled for the current A/B/OP.
            if (ovf) begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              r_a <= R;
              r_b <= SW[3:0];
              if (r_cc != CC_MAX) r_cc <= r_cc + 4'd1;
            end
          end else if (w_next) begin
            r_op <= r_op + 3'd1;
          end
        end
        S_ERROR: begin
          if (w_load) begin
            r_a     <= SW[7:4];
            r_b     <= SW[3:0];
            r_cc    <= '0;
            r_error <= 1'b0;
            r_state <= S_LOADED;
          end else if (w_next) begin
            r_op <= r_op + 3'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_loaded <= 1'b0;
        end
      endcase
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign OP         = r_op;
  assign Error      = r_error;
  assign Loaded     = r_loaded;
  assign ChainCount = r_cc;

endmodule
